// File: rtl/onehot_decoder_scan.sv
// Registered binary-to-one-hot decoder with direct load and prescaled auto-scan.
// Latency: 1 cycle from a load/step edge to out, idx and wrap (all outputs are flops).
// Backpressure: none; en=0 freezes idx/out in place and clears the prescaler.
module onehot_decoder_scan #(
    parameter  int IN_W  = 3,
    parameter  int DIV   = 4,
    localparam int OUT_W = 2**IN_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [IN_W-1:0]  sel_in,
    output logic [OUT_W-1:0] out,
    output logic [IN_W-1:0]  idx,
    output logic             wrap
);

    localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     psc;
    logic [PW-1:0]     psc_nxt;
    logic [IN_W-1:0]   idx_nxt;
    logic [OUT_W-1:0]  out_nxt;
    logic              wrap_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (en) begin
            state_nxt = mode ? SCAN : DECODE;
        end
    end

    // Actions key off the state being entered, so en/mode changes act on the same edge.
    // The prescaler only advances when already in SCAN; entering SCAN restarts a full period.
    always_comb begin
        idx_nxt  = idx;
        psc_nxt  = '0;
        wrap_nxt = 1'b0;
        case (state_nxt)
            DECODE: begin
                if (load) begin
                    idx_nxt = sel_in;
                end
            end
            SCAN: begin
                if (load) begin
                    idx_nxt = sel_in;
                end else if (state == SCAN) begin
                    if (psc == PS_MAX) begin
                        idx_nxt  = dir ? (idx - IN_W'(1)) : (idx + IN_W'(1));
                        wrap_nxt = dir ? (idx == '0) : (idx == '1);
                    end else begin
                        psc_nxt = psc + PW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
        out_nxt = OUT_W'(1) << idx_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx  <= '0;
            out  <= OUT_W'(1);
            wrap <= 1'b0;
            psc  <= '0;
        end else begin
            idx  <= idx_nxt;
            out  <= out_nxt;
            wrap <= wrap_nxt;
            psc  <= psc_nxt;
        end
    end

endmodule
